// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring shift-subtract unsigned divider
// One quotient bit per clock; start/busy/done handshake with held results.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH:0]    a;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  m;
    logic [CW-1:0]     cnt;

    logic [WIDTH+1:0]  trial;
    logic [WIDTH:0]    a_next;
    logic [WIDTH-1:0]  q_next;

    // A stays below M between steps, so its top bit is zero and the extra
    // guard bit of the trial difference only ever carries the borrow.
    always_comb begin
        trial  = {a, q[WIDTH-1]} - {2'b00, m};
        a_next = {a[WIDTH-1:0], q[WIDTH-1]};
        q_next = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            a_next = trial[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor != '0) begin
                            q     <= dividend;
                            a     <= '0;
                            m     <= divisor;
                            cnt   <= CW'(WIDTH);
                            state <= CALC;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                CALC: begin
                    a   <= a_next;
                    q   <= q_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient    <= q_next;
                        remainder   <= a_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // A divide by zero arrives here with done low and pulses it one edge later.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one division and records latency, busy/done counts and the result.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output int lat, output int busy_n, output int pulses,
                           output logic [7:0] qo, output logic [7:0] ro, output logic zo);
        lat = -1; busy_n = 0; pulses = 0; qo = 'x; ro = 'x; zo = 1'bx;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n += int'(busy);
        pulses += int'(done);
        for (int n = 1; n <= WIDTH + 5; n++) begin
            @(posedge clk); #1;
            busy_n += int'(busy);
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = n; qo = quotient; ro = remainder; zo = div_by_zero;
                end
            end
        end
    endtask

    task automatic test_reset;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
        if (remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_basic;
        int lat, bn, pn; logic [7:0] qo, ro; logic zo;
        run_div(8'd100, 8'd7, lat, bn, pn, qo, ro, zo);
        checks += 6;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        if (qo !== 8'd14) begin errors++; $display("FAIL basic_quotient: got %0d expected 14", qo); end
        if (ro !== 8'd2) begin errors++; $display("FAIL basic_remainder: got %0d expected 2", ro); end
        if (zo !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", zo); end
        if (bn !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 9", bn); end
        if (pn !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", pn); end
    endtask

    task automatic test_edges;
        logic [7:0] va [5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd128};
        logic [7:0] vb [5] = '{8'd1,   8'd9, 8'd3, 8'd255, 8'd2};
        logic [7:0] eq [5] = '{8'd255, 8'd0, 8'd0, 8'd1,   8'd64};
        logic [7:0] er [5] = '{8'd0,   8'd5, 8'd0, 8'd0,   8'd0};
        int lat, bn, pn; logic [7:0] qo, ro; logic zo;
        for (int i = 0; i < 5; i++) begin
            run_div(va[i], vb[i], lat, bn, pn, qo, ro, zo);
            checks += 4;
            if (lat !== 8) begin errors++; $display("FAIL edge%0d_latency: got %0d expected 8", i, lat); end
            if (qo !== eq[i]) begin errors++; $display("FAIL edge%0d_quotient: got %0d expected %0d", i, qo, eq[i]); end
            if (ro !== er[i]) begin errors++; $display("FAIL edge%0d_remainder: got %0d expected %0d", i, ro, er[i]); end
            if (zo !== 1'b0) begin errors++; $display("FAIL edge%0d_dbz: got %b expected 0", i, zo); end
        end
    endtask

    task automatic test_div_zero;
        int lat, bn, pn; logic [7:0] qo, ro; logic zo;
        run_div(8'd200, 8'd0, lat, bn, pn, qo, ro, zo);
        checks += 6;
        if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        if (qo !== 8'd255) begin errors++; $display("FAIL dbz_quotient: got %0d expected 255", qo); end
        if (ro !== 8'd200) begin errors++; $display("FAIL dbz_remainder: got %0d expected 200", ro); end
        if (zo !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", zo); end
        if (bn !== 2) begin errors++; $display("FAIL dbz_busy_cycles: got %0d expected 2", bn); end
        if (pn !== 1) begin errors++; $display("FAIL dbz_done_pulses: got %0d expected 1", pn); end
        run_div(8'd9, 8'd4, lat, bn, pn, qo, ro, zo);
        checks += 3;
        if (qo !== 8'd2) begin errors++; $display("FAIL after_dbz_quotient: got %0d expected 2", qo); end
        if (ro !== 8'd1) begin errors++; $display("FAIL after_dbz_remainder: got %0d expected 1", ro); end
        if (zo !== 1'b0) begin errors++; $display("FAIL after_dbz_flag: got %b expected 0", zo); end
    endtask

    task automatic test_ignore_start;
        int pn = 0; logic [7:0] qo = 'x, ro = 'x;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'd3; divisor = 8'd1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done) begin pn++; qo = quotient; ro = remainder; end
        end
        checks += 4;
        if (pn !== 1) begin errors++; $display("FAIL ignore_done_pulses: got %0d expected 1", pn); end
        if (qo !== 8'd14) begin errors++; $display("FAIL ignore_quotient: got %0d expected 14", qo); end
        if (ro !== 8'd2) begin errors++; $display("FAIL ignore_remainder: got %0d expected 2", ro); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat, bn, pn; logic [7:0] qo, ro; logic zo;
        int seen = 0;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        if (quotient !== 8'd0) begin errors++; $display("FAIL midrst_quotient: got %0d expected 0", quotient); end
        if (remainder !== 8'd0) begin errors++; $display("FAIL midrst_remainder: got %0d expected 0", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_dbz: got %b expected 0", div_by_zero); end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        checks += 1;
        if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen); end
        run_div(8'd9, 8'd4, lat, bn, pn, qo, ro, zo);
        checks += 3;
        if (lat !== 8) begin errors++; $display("FAIL midrst_after_latency: got %0d expected 8", lat); end
        if (qo !== 8'd2) begin errors++; $display("FAIL midrst_after_quotient: got %0d expected 2", qo); end
        if (ro !== 8'd1) begin errors++; $display("FAIL midrst_after_remainder: got %0d expected 1", ro); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b;
        int edge_n = 0, last_edge = -1, got = 0;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(1, 255));
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        while (got < 1000 && edge_n < 15000) begin
            @(posedge clk); #1;
            edge_n++;
            if (done) begin
                checks += 2;
                if (int'(quotient) * int'(b) + int'(remainder) != int'(a)) begin
                    errors++;
                    $display("FAIL sweep_identity: %0d/%0d gave q=%0d r=%0d", a, b, quotient, remainder);
                end
                if (remainder >= b) begin
                    errors++;
                    $display("FAIL sweep_rem_bound: got r=%0d expected below %0d", remainder, b);
                end
                if (last_edge >= 0) begin
                    checks += 1;
                    if (edge_n - last_edge != 10) begin
                        errors++;
                        $display("FAIL sweep_period: got %0d expected 10", edge_n - last_edge);
                    end
                end
                last_edge = edge_n;
                got++;
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(1, 255));
                dividend = a; divisor = b;
            end
        end
        start = 1'b0;
        checks += 1;
        if (got != 1000) begin errors++; $display("FAIL sweep_count: got %0d expected 1000", got); end
        repeat (12) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
